// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants and types for the fetch / IF-ID stage
package if_id_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INC      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - fetch PC flop with redirect / hold / +4 next-PC select
module pc_register
    import if_id_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_t     sel,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    // Fetch addresses are always word aligned, so the low bits of a target are dropped.
    logic [31:0] redirect_aligned;
    assign redirect_aligned = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_SEL_REDIRECT: pc <= redirect_aligned;
                PC_SEL_INC:      pc <= pc + PC_INC;
                default:         pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - fetch FSM, PC and IF/ID register; IF_ID_PERF_COUNT_EN adds stall/flush counters
module if_id_stage
    import if_id_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_inst,
    output logic        ID_valid,
`ifdef IF_ID_PERF_COUNT_EN
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`else
    output logic        halted
`endif
);

    fetch_state_t state;
    fetch_state_t next_state;
    pc_sel_t      pc_sel;
    logic [31:0]  id_pc_d;
    logic [31:0]  id_inst_d;
    logic         id_valid_d;
    logic         count_stall;
    logic         count_flush;

    pc_register #(.RESET_PC(RESET_PC)) u_pc_register (
        .clk         (clk),
        .reset       (reset),
        .sel         (pc_sel),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Priority in RUN: halt > flush > stall > advance; HALTED only bubbles.
    always_comb begin
        next_state  = state;
        pc_sel      = PC_SEL_HOLD;
        id_pc_d     = ID_pc;
        id_inst_d   = ID_inst;
        id_valid_d  = ID_valid;
        count_stall = 1'b0;
        count_flush = 1'b0;
        if (state == HALTED || halt) begin
            next_state = HALTED;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (flush) begin
            pc_sel      = PC_SEL_REDIRECT;
            id_pc_d     = pc;
            id_inst_d   = NOP_INST;
            id_valid_d  = 1'b0;
            count_flush = 1'b1;
        end else if (stall) begin
            count_stall = 1'b1;
        end else begin
            pc_sel     = PC_SEL_INC;
            id_pc_d    = pc;
            id_inst_d  = imem_inst;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ID_pc    <= RESET_PC;
            ID_inst  <= NOP_INST;
            ID_valid <= 1'b0;
        end else begin
            ID_pc    <= id_pc_d;
            ID_inst  <= id_inst_d;
            ID_valid <= id_valid_d;
        end
    end

    assign halted = (state == HALTED);

`ifdef IF_ID_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (count_stall && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (count_flush && flush_count != 32'hFFFF_FFFF) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`else
    logic unused_counts;
    assign unused_counts = count_stall ^ count_flush;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage with a behavioural reference model
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] imem_inst = 32'd0;
    logic [31:0] pc;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;
    logic        ID_valid;
    logic        halted;
`ifdef IF_ID_PERF_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc = 32'd0, m_id_pc = 32'd0, m_id_inst = NOP;
    logic        m_valid = 1'b0, m_halted = 1'b0;
    logic [31:0] m_sc = 32'd0, m_fc = 32'd0;

    if_id_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_inst   (imem_inst),
        .pc          (pc),
        .ID_pc       (ID_pc),
        .ID_inst     (ID_inst),
        .ID_valid    (ID_valid),
`ifdef IF_ID_PERF_COUNT_EN
        .halted      (halted),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
`else
        .halted      (halted)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_step();
        if (reset) begin
            m_pc = 32'd0; m_id_pc = 32'd0; m_id_inst = NOP; m_valid = 1'b0;
            m_halted = 1'b0; m_sc = 32'd0; m_fc = 32'd0;
        end else if (m_halted || halt) begin
            m_halted = 1'b1; m_id_inst = NOP; m_valid = 1'b0;
        end else if (flush) begin
            m_id_pc = m_pc;
            m_pc = {redirect_pc[31:2], 2'b00};
            m_id_inst = NOP; m_valid = 1'b0;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else if (stall) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else begin
            m_id_inst = imem_inst; m_id_pc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0; redirect_pc = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b1; halt = 1'b1; redirect_pc = 32'h0000_1234;
        tick();
        idle_inputs();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid, halted} !== {32'd0, 32'd0, NOP, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b halted=%b, want 0/0/%h/0/0",
                     pc, ID_pc, ID_inst, ID_valid, halted, NOP);
        end
`ifdef IF_ID_PERF_COUNT_EN
        tests_run++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: stall_cycles=%0d flush_count=%0d, want 0/0", stall_cycles, flush_count);
        end
`endif
    endtask

    task automatic test_straight_line();
        do_reset();
        imem_inst = 32'h00A0_0093;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h10, 32'hC, 32'h00A0_0093, 1'b1}) begin
            tests_failed++;
            $display("FAIL straight_line: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 10/c/00a00093/1",
                     pc, ID_pc, ID_inst, ID_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_inst = 32'h1111_1111; tick();
        imem_inst = 32'h2222_2222; tick();
        stall = 1'b1; imem_inst = 32'h3333_3333;
        tick(); tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h8, 32'h4, 32'h2222_2222, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_hold: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 8/4/22222222/1",
                     pc, ID_pc, ID_inst, ID_valid);
        end
`ifdef IF_ID_PERF_COUNT_EN
        tests_run++;
        if (stall_cycles !== 32'd2) begin
            tests_failed++;
            $display("FAIL stall_count: stall_cycles=%0d, want 2", stall_cycles);
        end
`endif
    endtask

    task automatic test_flush_stall();
        flush = 1'b1; stall = 1'b1; redirect_pc = 32'h43;
        tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h40, 32'h8, NOP, 1'b0}) begin
            tests_failed++;
            $display("FAIL flush_stall: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 40/8/%h/0",
                     pc, ID_pc, ID_inst, ID_valid, NOP);
        end
`ifdef IF_ID_PERF_COUNT_EN
        tests_run++;
        if ({stall_cycles, flush_count} !== {32'd2, 32'd1}) begin
            tests_failed++;
            $display("FAIL flush_count: stall_cycles=%0d flush_count=%0d, want 2/1", stall_cycles, flush_count);
        end
`endif
        idle_inputs(); imem_inst = 32'hABCD_0001;
        tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h44, 32'h40, 32'hABCD_0001, 1'b1}) begin
            tests_failed++;
            $display("FAIL after_flush: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 44/40/abcd0001/1",
                     pc, ID_pc, ID_inst, ID_valid);
        end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imem_inst = $urandom; tick();
        end
        halt = 1'b1; flush = 1'b1; redirect_pc = 32'h100;
        tick();
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stall = 1'($urandom_range(0, 1)); imem_inst = $urandom;
            tick();
            tests_run++;
            if ({halted, pc, ID_inst, ID_valid} !== {1'b1, 32'h20, NOP, 1'b0}) begin
                tests_failed++;
                $display("FAIL halt_freeze[%0d]: halted=%b pc=%h ID_inst=%h ID_valid=%b, want 1/20/%h/0",
                         i, halted, pc, ID_inst, ID_valid, NOP);
            end
        end
`ifdef IF_ID_PERF_COUNT_EN
        tests_run++;
        if ({stall_cycles, flush_count} !== 64'd0) begin
            tests_failed++;
            $display("FAIL halt_counters: stall_cycles=%0d flush_count=%0d, want 0/0", stall_cycles, flush_count);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        flush = 1'b0; imem_inst = 32'h5555_AAAA;
        tick();
        tests_run++;
        if ({pc, ID_pc, ID_valid} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin
            tests_failed++;
            $display("FAIL pc_wrap: pc=%h ID_pc=%h ID_valid=%b, want 0/fffffffc/1", pc, ID_pc, ID_valid);
        end
        tick(); tick();
        stall = 1'b1; tick(); tick();
        reset = 1'b1; tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h0, 32'h0, NOP, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 0/0/%h/0",
                     pc, ID_pc, ID_inst, ID_valid, NOP);
        end
        idle_inputs(); imem_inst = 32'h0BAD_F00D;
        tick();
        tests_run++;
        if ({pc, ID_pc, ID_inst, ID_valid} !== {32'h4, 32'h0, 32'h0BAD_F00D, 1'b1}) begin
            tests_failed++;
            $display("FAIL first_after_reset: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b, want 4/0/0badf00d/1",
                     pc, ID_pc, ID_inst, ID_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) < (m_halted ? 20 : 2));
            halt        = ($urandom_range(0, 99) < 2);
            flush       = ($urandom_range(0, 99) < 20);
            stall       = ($urandom_range(0, 99) < 25);
            redirect_pc = $urandom;
            imem_inst   = $urandom;
            tick();
            tests_run++;
            if ({pc, ID_pc, ID_inst, ID_valid, halted} !== {m_pc, m_id_pc, m_id_inst, m_valid, m_halted}) begin
                tests_failed++;
                $display("FAIL random[%0d]: pc=%h ID_pc=%h ID_inst=%h ID_valid=%b halted=%b, want %h/%h/%h/%b/%b",
                         i, pc, ID_pc, ID_inst, ID_valid, halted, m_pc, m_id_pc, m_id_inst, m_valid, m_halted);
            end
`ifdef IF_ID_PERF_COUNT_EN
            tests_run++;
            if ({stall_cycles, flush_count} !== {m_sc, m_fc}) begin
                tests_failed++;
                $display("FAIL random_counters[%0d]: stall_cycles=%0d flush_count=%0d, want %0d/%0d",
                         i, stall_cycles, flush_count, m_sc, m_fc);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_stall();
        test_flush_stall();
        test_halt();
        test_wrap_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
